// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_adder: chunk sizing, split legality and saturation limits.
// Saturation constants are only consumed when PIPE_ADDER_SAT_EN is defined.
package pipe_adder_pkg;

    localparam int unsigned MaxWidth = 1024;

    function automatic bit split_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    // Signed limit for a width-bit word: 0111..1 or 1000..0, zero-extended to MaxWidth.
    function automatic logic [MaxWidth-1:0] sat_limit(input int unsigned width,
                                                      input logic negative);
        logic [MaxWidth-1:0] lim;
        lim = '0;
        for (int unsigned i = 0; i + 1 < width; i++) begin
            lim[i] = ~negative;
        end
        lim[width-1] = negative;
        return lim;
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One CW-bit chunk of the pipelined adder plus its valid/data register slice.
// With PIPE_ADDER_SAT_EN defined, the last stage clamps overflowing results.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 8,
    parameter int unsigned IDX   = 0,
    parameter bit          LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_a,
    output logic [WIDTH-1:0] dn_b,
    output logic [WIDTH-1:0] dn_sum,
    output logic             dn_carry,
    output logic             dn_ovf
);

    localparam int unsigned Lo = IDX * CW;

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [MaxWidth-1:0] SatMaxFull = sat_limit(WIDTH, 1'b0);
    localparam logic [MaxWidth-1:0] SatMinFull = sat_limit(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0]    SatMax     = SatMaxFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    SatMin     = SatMinFull[WIDTH-1:0];
`endif

    logic             valid_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             carry_q, ovf_q;

    logic [CW-1:0] a_chunk, b_chunk, s_chunk;
    logic          c_chunk, c_msb, ovf_d, load;

    assign a_chunk = up_a[Lo +: CW];
    assign b_chunk = up_b[Lo +: CW];
    assign {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, up_carry};

    // Carry into the chunk MSB recovered from its sum bit; works for CW=1 too.
    assign c_msb = a_chunk[CW-1] ^ b_chunk[CW-1] ^ s_chunk[CW-1];
    assign ovf_d = c_msb ^ c_chunk;

    assign up_ready = !valid_q || dn_ready;
    assign load     = up_valid && up_ready;

    always_comb begin
        sum_d            = up_sum;
        sum_d[Lo +: CW]  = s_chunk;
`ifdef PIPE_ADDER_SAT_EN
        if (LAST && ovf_d) begin
            sum_d = up_a[WIDTH-1] ? SatMin : SatMax;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (up_ready) begin
                valid_q <= up_valid;
            end
            if (load) begin
                a_q     <= up_a;
                b_q     <= up_b;
                sum_q   <= sum_d;
                carry_q <= c_chunk;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign dn_valid = valid_q;
    assign dn_a     = a_q;
    assign dn_b     = b_q;
    assign dn_sum   = sum_q;
    assign dn_carry = carry_q;
    assign dn_ovf   = ovf_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-chained chunks, valid/ready both sides.
// Define PIPE_ADDER_SAT_EN to clamp signed-overflowing results to the signed limit.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $fatal(1, "pipe_adder: WIDTH must be divisible by STAGES, 1 <= STAGES <= WIDTH");
    end

    // Index k is the boundary feeding stage k; index STAGES is the output side.
    logic             valid_p [STAGES+1];
    logic             ready_p [STAGES+1];
    logic [WIDTH-1:0] a_p     [STAGES+1];
    logic [WIDTH-1:0] b_p     [STAGES+1];
    logic [WIDTH-1:0] sum_p   [STAGES+1];
    logic             carry_p [STAGES+1];
    logic             ovf_p   [STAGES];

    assign valid_p[0] = in_valid;
    assign in_ready   = ready_p[0];
    assign a_p[0]     = a;
    assign b_p[0]     = sub ? ~b : b;
    assign sum_p[0]   = '0;
    assign carry_p[0] = sub | c_in;

    assign ready_p[STAGES] = out_ready;
    assign out_valid       = valid_p[STAGES];
    assign sum             = sum_p[STAGES];
    assign c_out           = carry_p[STAGES];
    assign ovf             = ovf_p[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (k),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (valid_p[k]),
            .up_ready (ready_p[k]),
            .up_a     (a_p[k]),
            .up_b     (b_p[k]),
            .up_sum   (sum_p[k]),
            .up_carry (carry_p[k]),
            .dn_valid (valid_p[k+1]),
            .dn_ready (ready_p[k+1]),
            .dn_a     (a_p[k+1]),
            .dn_b     (b_p[k+1]),
            .dn_sum   (sum_p[k+1]),
            .dn_carry (carry_p[k+1]),
            .dn_ovf   (ovf_p[k])
        );
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed table-driven bench for pipe_adder (WIDTH=32, STAGES=4); honours PIPE_ADDER_SAT_EN.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        c_in, sub, c_out, ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (32),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c_in;
        logic        sub;
        logic [31:0] sum_wrap;
        logic [31:0] sum_sat;
        logic        c_out;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic ci,
                                input logic sb, input logic [31:0] sw, input logic [31:0] ss,
                                input logic co, input logic ov);
        vec_t v;
        v.a = va; v.b = vb; v.c_in = ci; v.sub = sb;
        v.sum_wrap = sw; v.sum_sat = ss; v.c_out = co; v.ovf = ov;
        return v;
    endfunction

    function automatic logic [31:0] exp_sum(input vec_t v);
`ifdef PIPE_ADDER_SAT_EN
        return v.sum_sat;
`else
        return v.sum_wrap;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        a = v.a; b = v.b; c_in = v.c_in; sub = v.sub;
    endtask

    // Single transaction: checks acceptance, 4-cycle latency, result fields, single emission.
    task automatic run_one(input int idx);
        int lat;
        drive(vecs[idx]);
        chk1($sformatf("v%0d in_ready", idx), in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, 4);
        chk($sformatf("v%0d sum", idx), sum, exp_sum(vecs[idx]));
        chk1($sformatf("v%0d c_out", idx), c_out, vecs[idx].c_out);
        chk1($sformatf("v%0d ovf", idx), ovf, vecs[idx].ovf);
        tick();
        chk1($sformatf("v%0d out_valid drop", idx), out_valid, 1'b0);
    endtask

    logic [31:0] bp_exp[4];
    int          accepted, received;

    initial begin
        vecs[0]  = mk(32'h1, 32'h0, 1'b0, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0);
        vecs[1]  = mk(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[2]  = mk(32'd128, 32'd64, 1'b1, 1'b0, 32'd193, 32'd193, 1'b0, 1'b0);
        vecs[3]  = mk(32'd33, 32'd89, 1'b0, 1'b0, 32'd122, 32'd122, 1'b0, 1'b0);
        vecs[4]  = mk(32'd255, 32'd89, 1'b0, 1'b0, 32'd344, 32'd344, 1'b0, 1'b0);
        vecs[5]  = mk(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0);
        vecs[6]  = mk(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
        vecs[7]  = mk(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        vecs[8]  = mk(32'd7, 32'd7, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[9]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      1'b1, 1'b0);
        vecs[10] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 1'b1, 1'b1);
        vecs[11] = mk(32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[12] = mk(32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        vecs[13] = mk(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        #12;
        chk1("reset out_valid", out_valid, 1'b0);
        chk("reset sum", sum, 32'h0);
        chk1("reset c_out", c_out, 1'b0);
        chk1("reset ovf", ovf, 1'b0);
        chk1("reset in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_one(i);
        end

        // Back-to-back stream: four results on consecutive cycles starting at cycle 4.
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 4) begin
                drive(vecs[2 + cyc]);
                chk1($sformatf("stream in_ready c%0d", cyc), in_ready, 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (cyc + 1 >= 4 && cyc + 1 < 8) begin
                chk1($sformatf("stream out_valid c%0d", cyc + 1), out_valid, 1'b1);
                chk($sformatf("stream sum c%0d", cyc + 1), sum, exp_sum(vecs[cyc - 1]));
                chk1($sformatf("stream c_out c%0d", cyc + 1), c_out, vecs[cyc - 1].c_out);
            end else begin
                chk1($sformatf("stream idle c%0d", cyc + 1), out_valid, 1'b0);
            end
        end

        // Back-pressure: fill the pipe with out_ready low, then drain in order.
        out_ready = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = 1'b1; sub = 1'b0; c_in = 1'b0;
            a = 32'(accepted * 10 + 1);
            b = 32'(accepted);
            if (accepted < 4) bp_exp[accepted] = 32'(accepted * 11 + 1);
            if (in_ready) accepted++;
            tick();
            if (cyc >= 4) begin
                chk1($sformatf("bp hold out_valid c%0d", cyc), out_valid, 1'b1);
                chk($sformatf("bp hold sum c%0d", cyc), sum, 32'h1);
            end
        end
        chk("bp accepted", accepted, 4);
        chk1("bp in_ready low", in_ready, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        received = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) begin
                if (received < 4) begin
                    chk($sformatf("bp drain %0d", received), sum, bp_exp[received]);
                end
                received++;
            end
            tick();
        end
        chk("bp received", received, 4);

        // Reset with three items in flight; nothing stale may appear afterwards.
        for (int i = 0; i < 3; i++) begin
            drive(vecs[2 + i]);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("midrst out_valid", out_valid, 1'b0);
        chk("midrst sum", sum, 32'h0);
        chk1("midrst in_ready", in_ready, 1'b1);
        #3;
        rst_n = 1'b1;
        received = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (out_valid) received++;
        end
        chk("midrst stale outputs", received, 0);
        run_one(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
